// File: rtl/mnist_pkg.sv
// Shared types and helpers for the dense-layer engine: FSM states, default widths, saturating add.
package mnist_pkg;

    localparam int N_IN_DEF   = 784;
    localparam int N_OUT_DEF  = 10;
    localparam int DATA_W_DEF = 8;
    localparam int WGT_W_DEF  = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Operands arrive sign-extended to 64 bits; the sum is clamped to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        return s;
    endfunction

endpackage

// File: rtl/mnist_mac_lane.sv
// One class lane: bias preload, unsigned-pixel x signed-weight MAC with saturation, ReLU on the score.
// score_o is combinational from the next accumulator value so the final pixel is included at capture.
module mnist_mac_lane
    import mnist_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              relu_en_i,
    input  logic [ACC_W-1:0]  bias_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic [WGT_W-1:0]  wgt_i,
    output logic [ACC_W-1:0]  score_o
);

    localparam int PW = DATA_W + WGT_W + 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    relu_q, relu_d;
    logic signed [PW-1:0]    pix_x, wgt_x, prod;
    logic signed [63:0]      sum;

    always_comb begin
        pix_x  = {{(PW - DATA_W){1'b0}}, pix_i};
        wgt_x  = {{(PW - WGT_W){wgt_i[WGT_W-1]}}, wgt_i};
        prod   = pix_x * wgt_x;
        sum    = sat_add({{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q},
                         {{(64 - PW){prod[PW-1]}}, prod}, ACC_W);
        acc_d  = acc_q;
        relu_d = relu_q;
        if (load_i) begin
            acc_d  = $signed(bias_i);
            relu_d = relu_en_i;
        end else if (en_i) begin
            acc_d = sum[ACC_W-1:0];
        end
        score_o = (relu_q && acc_d[ACC_W-1]) ? '0 : acc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            relu_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            relu_q <= relu_d;
        end
    end

endmodule

// File: rtl/mnist_dense_engine.sv
// Dense-layer engine: streams N_IN pixels into N_OUT parallel MAC lanes, then scans for the argmax.
// Start accept to done pulse is N_IN + N_OUT + 1 cycles; start is ignored outside IDLE.
module mnist_dense_engine
    import mnist_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int IDX_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    output logic [ADDR_W-1:0]      counter1,
    input  logic [DATA_W-1:0]      image,
    output logic [ADDR_W-1:0]      w_addr,
    input  logic [N_OUT*WGT_W-1:0] w_data,
    input  logic [N_OUT*ACC_W-1:0] bias,
    output logic                   busy,
    output logic                   done,
    output logic [N_OUT*ACC_W-1:0] result,
    output logic [IDX_W-1:0]       class_idx
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_OUT - 1);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [N_OUT*ACC_W-1:0]   result_q, result_d;
    logic [IDX_W-1:0]         scan_q, scan_d;
    logic [IDX_W-1:0]         best_q, best_d;
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic [IDX_W-1:0]         cls_q, cls_d;
    logic                     lane_load, lane_run;
    logic signed [ACC_W-1:0]  cur;
    logic [N_OUT*ACC_W-1:0]   score_all;
    logic signed [ACC_W-1:0]  res_lane [N_OUT];

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        mnist_mac_lane #(
            .DATA_W (DATA_W),
            .WGT_W  (WGT_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_i    (lane_load),
            .en_i      (lane_run),
            .relu_en_i (relu_en),
            .bias_i    (bias[k*ACC_W +: ACC_W]),
            .pix_i     (image),
            .wgt_i     (w_data[k*WGT_W +: WGT_W]),
            .score_o   (score_all[k*ACC_W +: ACC_W])
        );
        assign res_lane[k] = result_q[k*ACC_W +: ACC_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        scan_d    = scan_q;
        best_d    = best_q;
        max_d     = max_q;
        cls_d     = cls_q;
        lane_load = 1'b0;
        lane_run  = 1'b0;
        cur       = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    lane_load = 1'b1;
                end
            end
            RUN: begin
                lane_run = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Lane scores already include this final pixel.
                    cnt_d    = '0;
                    result_d = score_all;
                    scan_d   = '0;
                    state_d  = ARGMAX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARGMAX: begin
                cur = res_lane[scan_q];
                if (scan_q == '0 || cur > max_q) begin
                    max_d  = cur;
                    best_d = scan_q;
                end
                if (scan_q == IDX_LAST)
                    state_d = DONE;
                else
                    scan_d = scan_q + 1'b1;
            end
            default: begin
                cls_d   = best_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            scan_q   <= '0;
            best_q   <= '0;
            max_q    <= '0;
            cls_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            scan_q   <= scan_d;
            best_q   <= best_d;
            max_q    <= max_d;
            cls_q    <= cls_d;
        end
    end

    assign counter1  = cnt_q;
    assign w_addr    = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign class_idx = cls_q;

endmodule

// File: tb/tb_mnist_dense_engine.sv
// Scoreboard bench: stimulus pushes model results at start, a negedge monitor checks each done pulse.
module tb_mnist_dense_engine;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 10;
    localparam int IDX_W  = $clog2(N_OUT);
    localparam int LAT    = N_IN + N_OUT + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   relu_en = 1'b0;
    logic [ADDR_W-1:0]      counter1;
    logic [DATA_W-1:0]      image;
    logic [ADDR_W-1:0]      w_addr;
    logic [N_OUT*WGT_W-1:0] w_data;
    logic [N_OUT*ACC_W-1:0] bias;
    logic                   busy;
    logic                   done;
    logic [N_OUT*ACC_W-1:0] result;
    logic [IDX_W-1:0]       class_idx;

    mnist_dense_engine #(
        .N_IN (N_IN), .N_OUT (N_OUT), .DATA_W (DATA_W),
        .WGT_W (WGT_W), .ACC_W (ACC_W), .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk), .reset (rst_n), .start (start), .relu_en (relu_en),
        .counter1 (counter1), .image (image), .w_addr (w_addr), .w_data (w_data),
        .bias (bias), .busy (busy), .done (done), .result (result), .class_idx (class_idx)
    );

    always #5 clk = ~clk;

    int img [N_IN];
    int wrom [N_IN][N_OUT];
    int bias_v [N_OUT];

    // xmem and weight ROM: combinational reads at the DUT addresses
    always_comb begin
        image  = '0;
        w_data = '0;
        bias   = '0;
        if (int'(counter1) < N_IN)
            image = DATA_W'(img[int'(counter1)]);
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(w_addr) < N_IN)
                w_data[k*WGT_W +: WGT_W] = WGT_W'(wrom[int'(w_addr)][k]);
            bias[k*ACC_W +: ACC_W] = ACC_W'(bias_v[k]);
        end
    end

    typedef struct {
        int res [N_OUT];
        int cls;
        int t0;
    } exp_t;

    exp_t exp_q [$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int lane_val(input int k);
        logic signed [ACC_W-1:0] v;
        v = result[k*ACC_W +: ACC_W];
        return int'(v);
    endfunction

    // Reference: per-pixel saturating dot product, optional ReLU, first-max argmax.
    task automatic issue_now();
        exp_t   e;
        longint acc, hi, lo;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -(longint'(1) << (ACC_W - 1));
        for (int k = 0; k < N_OUT; k++) begin
            acc = bias_v[k];
            for (int p = 0; p < N_IN; p++) begin
                acc = acc + longint'(img[p]) * longint'(wrom[p][k]);
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end
            if (relu_en && acc < 0) acc = 0;
            e.res[k] = int'(acc);
        end
        e.cls = 0;
        for (int k = 1; k < N_OUT; k++)
            if (e.res[k] > e.res[e.cls]) e.cls = k;
        e.t0 = cyc + 1;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue();
        @(negedge clk);
        issue_now();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_OUT; k++)
            chk($sformatf("hold_result%0d", k), lane_val(k), last_exp.res[k]);
        chk("hold_class", class_idx, last_exp.cls);
    endtask

    task automatic set_case(input int i0, i1, i2, i3, w0, w1, w2, b0, b1, b2);
        img[0] = i0; img[1] = i1; img[2] = i2; img[3] = i3;
        for (int p = 0; p < N_IN; p++) begin
            wrom[p][0] = w0; wrom[p][1] = w1; wrom[p][2] = w2;
        end
        bias_v[0] = b0; bias_v[1] = b1; bias_v[2] = b2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_counter1"}, counter1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_class"}, class_idx, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy)
                chk("w_addr_eq_counter1", w_addr, counter1);
            if (done) begin
                chk("done_single_cycle", prev_done, 0);
                chk("busy_at_done", busy, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                    for (int k = 0; k < N_OUT; k++)
                        chk($sformatf("result%0d", k), lane_val(k), last_exp.res[k]);
                    chk("class_idx", class_idx, last_exp.cls);
                    chk("latency", cyc - last_exp.t0, LAT);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        for (int p = 0; p < N_IN; p++) begin
            img[p] = 0;
            for (int k = 0; k < N_OUT; k++) wrom[p][k] = 0;
        end
        for (int k = 0; k < N_OUT; k++) bias_v[k] = 0;

        #23;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic dot product, then with ReLU
        set_case(1, 2, 3, 4, 1, 2, -1, 0, 0, 0);
        relu_en = 1'b0; issue(); wait_idle(); check_hold();
        relu_en = 1'b1; issue(); wait_idle(); check_hold();
        // Bias only
        set_case(1, 2, 3, 4, 0, 0, 0, 5, 0, 0);
        issue(); wait_idle();
        relu_en = 1'b0;
        // Tie resolves to lowest index
        set_case(1, 2, 3, 4, 1, 1, 1, 0, 3, 3);
        issue(); wait_idle();
        // Positive and negative saturation
        set_case(255, 255, 255, 255, 127, -128, 0, 32700, -32700, 0);
        issue(); wait_idle(); check_hold();

        // Start pulses during RUN must not disturb the run
        set_case(1, 2, 3, 4, 1, 2, -1, 0, 0, 0);
        issue();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-run
        issue();
        for (int n = 0; n < 20 && counter1 != 2; n++) @(negedge clk);
        chk("reached_counter1_2", counter1, 2);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        chk("no_done_after_reset", done, 0);
        set_case(4, 3, 2, 1, -1, 1, 2, 7, -3, 0);
        issue(); wait_idle();

        // Back-to-back: second start during the done cycle
        set_case(1, 2, 3, 4, 1, 2, -1, 0, 0, 0);
        issue();
        for (int n = 0; n < 50 && !done; n++) @(negedge clk);
        chk("b2b_first_done", done, 1);
        set_case(9, 8, 7, 6, 3, -2, 1, 0, 100, -5);
        issue_now();
        wait_idle();

        // Randomised images, weights, biases and ReLU
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < N_IN; p++) begin
                img[p] = int'($urandom_range(255));
                for (int k = 0; k < N_OUT; k++)
                    wrom[p][k] = int'($urandom_range(255)) - 128;
            end
            for (int k = 0; k < N_OUT; k++)
                bias_v[k] = (it % 3 == 0) ? int'($urandom_range(65535)) - 32768
                                          : int'($urandom_range(2000)) - 1000;
            relu_en = 1'($urandom_range(1));
            issue();
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
